// File: rtl/alu64bit_pkg.sv
// Shared constants and opcode encoding for the 64-bit ALU.
// Used by alu1bit and alu_64bit.
package alu64bit_pkg;

   localparam int WIDTH = 64;

   typedef enum logic [1:0] {
      OP_NOR = 2'b00,
      OP_XOR = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } op_t;

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: full adder plus NOR/XOR mux.
// b is inverted locally for subtraction.
module alu1bit
   import alu64bit_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  op_t  op,
   output logic s,
   output logic cout
);

   logic bx;
   logic p;

   assign bx = (op == OP_SUB) ? ~b : b;
   assign p  = a ^ bx;

   always_comb begin
      s    = 1'b0;
      cout = 1'b0;
      unique case (op)
         OP_NOR: s = ~(a | b);
         OP_XOR: s = a ^ b;
         OP_ADD,
         OP_SUB: begin
            s    = p ^ cin;
            cout = (a & bx) | (cin & p);
         end
         default: begin
            s    = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_64bit.sv
// 64-bit ripple ALU with registered result.
// Optional signed overflow output: define ALU64BIT_OVF_EN.
module alu_64bit
   import alu64bit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
`ifdef ALU64BIT_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   op_t              op_e;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, cout_q;

   assign op_e = op_t'(op);
   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      alu1bit u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .op   (op_e),
         .s    (s_d[i]),
         .cout (c[i+1])
      );
   end

   assign cout_d = c[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

`ifdef ALU64BIT_OVF_EN
   logic ovf_d, ovf_q;

   always_comb begin
      ovf_d = 1'b0;
      unique case (op_e)
         OP_ADD: ovf_d = (a[WIDTH-1] == b[WIDTH-1]) &
                         (s_d[WIDTH-1] != a[WIDTH-1]);
         OP_SUB: ovf_d = (a[WIDTH-1] != b[WIDTH-1]) &
                         (s_d[WIDTH-1] != a[WIDTH-1]);
         default: ovf_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed table, reset
// sequences and a random sweep against a 65-bit reference.
module tb_alu_64bit;
   import alu64bit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] a, b;
   logic        cin;
   logic [1:0]  op;
   logic [63:0] s;
   logic        cout;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_64bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .op    (op),
`ifdef ALU64BIT_OVF_EN
      .ovf   (ovf),
`endif
      .s     (s),
      .cout  (cout)
   );

`ifndef ALU64BIT_OVF_EN
   assign ovf = 1'b0;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [63:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[14];

   task automatic chk64(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(logic [1:0] o, logic [63:0] x, logic [63:0] y,
                        logic ci);
      @(negedge clk);
      op = o; a = x; b = y; cin = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic ref_model(input logic [1:0] o, input logic [63:0] x,
                            input logic [63:0] y, input logic ci,
                            output logic [63:0] rs, output logic rc,
                            output logic rv);
      logic [64:0] t;
      t  = '0;
      rc = 1'b0;
      rv = 1'b0;
      case (o)
         2'b00: rs = ~(x | y);
         2'b01: rs = x ^ y;
         2'b10: begin
            t  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            rs = t[63:0];
            rc = t[64];
            rv = (x[63] == y[63]) && (rs[63] != x[63]);
         end
         default: begin
            t  = {1'b0, x} + {1'b0, ~y} + {64'd0, ci};
            rs = t[63:0];
            rc = t[64];
            rv = (x[63] != y[63]) && (rs[63] != x[63]);
         end
      endcase
   endtask

   initial begin
      logic [63:0] es;
      logic        ec, ev;
      logic [1:0]  ro;
      logic [63:0] ra, rb;
      logic        rci;

      vecs[0]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[1]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                   64'd0, 1'b1, 1'b0};
      vecs[2]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[3]  = '{2'b11, 64'd10, 64'd3, 1'b1, 64'd7, 1'b1, 1'b0};
      vecs[4]  = '{2'b11, 64'd3, 64'd10, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0};
      vecs[5]  = '{2'b00, 64'hF0F0_F0F0_F0F0_F0F0,
                   64'h0F0F_0000_0000_0000, 1'b1,
                   64'h0000_0F0F_0F0F_0F0F, 1'b0, 1'b0};
      vecs[6]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[7]  = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[8]  = '{2'b11, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[9]  = '{2'b11, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
      vecs[10] = '{2'b11, 64'd5, 64'd5, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[11] = '{2'b10, 64'h8000_0000_0000_0000,
                   64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
      vecs[12] = '{2'b00, 64'd0, 64'd0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[13] = '{2'b01, 64'hA5A5_A5A5_A5A5_A5A5,
                   64'h5A5A_5A5A_5A5A_5A5A, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

      // Reset with nonzero inputs pending across an edge
      rst_n = 1'b0;
      op = 2'b10; a = 64'd123; b = 64'd456; cin = 1'b1;
      #2;
      chk64("reset_s", s, 64'd0);
      chk1("reset_cout", cout, 1'b0);
      @(posedge clk); #1;
      chk64("reset_hold_s", s, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op = 2'b10; a = 64'd5; b = 64'd3; cin = 1'b0;
      #1;
      chk64("release_pre_edge_s", s, 64'd0);
      @(posedge clk); #1;
      chk64("first_add_s", s, 64'd8);
      chk1("first_add_cout", cout, 1'b0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
         chk64($sformatf("vec%0d_s", i), s, vecs[i].s);
         chk1($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
`ifdef ALU64BIT_OVF_EN
         chk1($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      end

      // Mid-operation reset discards the in-flight result
      drive(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      chk1("pre_midreset_cout", cout, 1'b1);
      @(negedge clk);
      op = 2'b10; a = 64'd1; b = 64'd1; cin = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk64("midreset_s", s, 64'd0);
      chk1("midreset_cout", cout, 1'b0);
      chk1("midreset_ovf", ovf, 1'b0);
      @(posedge clk); #1;
      chk64("midreset_edge_s", s, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk64("after_midreset_s", s, 64'd2);

      for (int i = 0; i < 10000; i++) begin
         ro  = 2'($urandom_range(0, 3));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rci = 1'($urandom_range(0, 1));
         if (i % 8 == 0) rb = ~ra;
         drive(ro, ra, rb, rci);
         ref_model(ro, ra, rb, rci, es, ec, ev);
         chk64($sformatf("rand%0d_s", i), s, es);
         chk1($sformatf("rand%0d_cout", i), cout, ec);
`ifdef ALU64BIT_OVF_EN
         chk1($sformatf("rand%0d_ovf", i), ovf, ev);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
